// File: rtl/clock_set_ctrl.sv
// Mode and time-setting controller for the time-of-day datapath.
// Synchronizes the push-buttons, runs the RUN/SET_HR/SET_MIN/SET_SEC FSM
// and issues single-cycle adjust strobes plus blink control.
module clock_set_ctrl #(
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000,
    parameter int unsigned BLINK_HALF   = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    input  logic       key_dec_n,
    input  logic       tick_1hz,
    output logic       run_en,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       dec_min,
    output logic       inc_hr,
    output logic       dec_hr,
    output logic       clr_sec,
    output logic       pre_clr,
    output logic [1:0] mode,
    output logic [2:0] blink_sel,
    output logic       blink_on
);

    localparam int unsigned HOLD_W  = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSetHr  = 2'd1,
        StSetMin = 2'd2,
        StSetSec = 2'd3
    } state_t;

    state_t               state;
    logic   [2:0]         sync1, sync2, prev;  // bit 2 mode, bit 1 inc, bit 0 dec
    logic                 hold_act, hold_inc;
    logic   [HOLD_W-1:0]  hold_cnt;
    logic   [BLINK_W-1:0] blink_cnt;

    logic              mode_press, inc_press, dec_press;
    logic              inc_low, dec_low, adj_mode;
    logic              inc_req, dec_req, hold_go, rep_fire;
    logic [HOLD_W-1:0] hold_nxt;
    state_t            state_nxt;

    function automatic logic [2:0] sel_of(input state_t s);
        logic [2:0] r;
        unique case (s)
            StSetHr:  r = 3'b100;
            StSetMin: r = 3'b010;
            StSetSec: r = 3'b001;
            default:  r = 3'b000;
        endcase
        return r;
    endfunction

    // Two-flop synchronizer plus previous-value register; idle level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
            prev  <= 3'b111;
        end else begin
            sync1 <= {key_mode_n, key_inc_n, key_dec_n};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Press detection, priority resolution and auto-repeat qualification
    always_comb begin
        mode_press = prev[2] & ~sync2[2];
        inc_press  = prev[1] & ~sync2[1];
        dec_press  = prev[0] & ~sync2[0];
        inc_low    = ~sync2[1];
        dec_low    = ~sync2[0];
        adj_mode   = (state == StSetHr) || (state == StSetMin);
        // An adjust press is void if the mode key wins or the other key is also down
        inc_req    = inc_press & ~dec_low & ~mode_press & (state != StRun);
        dec_req    = dec_press & ~inc_low & ~mode_press & (state != StRun);
        hold_go    = hold_act & adj_mode & ~mode_press &
                     (hold_inc ? (inc_low & ~dec_low) : (dec_low & ~inc_low));
        hold_nxt   = hold_cnt + HOLD_W'(1);
        rep_fire   = hold_go && (hold_nxt == HOLD_W'(REPEAT_DELAY));
        state_nxt  = state_t'(state + 2'd1);
    end

    // FSM, hold/blink counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StRun;
            run_en    <= 1'b1;
            inc_sec   <= 1'b0;
            inc_min   <= 1'b0;
            dec_min   <= 1'b0;
            inc_hr    <= 1'b0;
            dec_hr    <= 1'b0;
            clr_sec   <= 1'b0;
            pre_clr   <= 1'b0;
            blink_sel <= 3'b000;
            blink_on  <= 1'b1;
            blink_cnt <= '0;
            hold_act  <= 1'b0;
            hold_inc  <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            // A mode press in RUN stops the clock, so a coincident tick is dropped
            inc_sec <= (state == StRun) & tick_1hz & ~mode_press;
            inc_hr  <= (state == StSetHr)  & (inc_req | (rep_fire &  hold_inc));
            dec_hr  <= (state == StSetHr)  & (dec_req | (rep_fire & ~hold_inc));
            inc_min <= (state == StSetMin) & (inc_req | (rep_fire &  hold_inc));
            dec_min <= (state == StSetMin) & (dec_req | (rep_fire & ~hold_inc));
            clr_sec <= (state == StSetSec) & (inc_req | dec_req);

            if (adj_mode && (inc_req || dec_req)) begin
                hold_act <= 1'b1;
                hold_inc <= inc_req;
                hold_cnt <= '0;
            end else if (hold_go) begin
                // After a repeat, rewind so the next one lands REPEAT_RATE later
                hold_cnt <= rep_fire ? HOLD_W'(REPEAT_DELAY - REPEAT_RATE) : hold_nxt;
            end else begin
                hold_act <= 1'b0;
                hold_cnt <= '0;
            end

            if (mode_press) begin
                state     <= state_nxt;
                run_en    <= (state_nxt == StRun);
                pre_clr   <= (state == StSetSec);
                blink_sel <= sel_of(state_nxt);
                blink_on  <= 1'b1;
                blink_cnt <= '0;
            end else begin
                pre_clr <= 1'b0;
                if (state != StRun) begin
                    if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
                        blink_cnt <= '0;
                        blink_on  <= ~blink_on;
                    end else begin
                        blink_cnt <= blink_cnt + BLINK_W'(1);
                    end
                end
            end
        end
    end

    assign mode = state;

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Mode and time-setting controller for the clock_top time-of-day datapath (hr/min/sec counters, HEX display). It synchronizes and edge-detects the raw active-low push-buttons and runs the RUN/SET_HR/SET_MIN/SET_SEC state machine. It arbitrates between the 1 Hz tick and user adjustments, and issues single-cycle increment, decrement and clear strobes to the counters plus blink control to the display driver.

Parameters:
REPEAT_DELAY, 25000000, cycles of continuous hold before the first auto-repeat pulse
REPEAT_RATE, 5000000, cycles between subsequent auto-repeat pulses
BLINK_HALF, 12500000, cycles per blink half-period in set modes

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_mode_n  input  1  raw mode button, active-low, asynchronous to clk
key_inc_n  input  1  raw increment button, active-low, asynchronous
key_dec_n  input  1  raw decrement button, active-low, asynchronous
tick_1hz  input  1  one-cycle pulse from the seconds prescaler
run_en  output  1  1 = timekeeping advances
inc_sec  output  1  one-cycle strobe: seconds +1 with carry
inc_min / dec_min  output  1 each  one-cycle strobes: minutes ±1, wrap 59<->0, no carry to hours
inc_hr / dec_hr  output  1 each  one-cycle strobes: hours ±1, wrap 23<->0
clr_sec  output  1  one-cycle strobe: seconds <- 0
pre_clr  output  1  one-cycle strobe: clear the prescaler phase
mode  output  2  0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC
blink_sel  output  3  one-hot field being set: [2] hr, [1] min, [0] sec; 000 in RUN
blink_on  output  1  1 = selected field visible

Behaviour:
- Reset (async, rst_n low): state RUN; mode=0, run_en=1, all strobes 0, blink_on=1, blink_sel=000; sync/hold/blink counters cleared. Mid-operation reset aborts any set mode and returns to RUN.
- Input conditioning: each key passes through a 2-flop synchronizer, then a previous-value register. A press is a 1->0 transition of the synchronized level. Strobes are registered, 1 cycle wide, and asserted on the 3rd rising edge after the first edge that samples the key low.
- FSM, advanced by a mode press: RUN->SET_HR->SET_MIN->SET_SEC->RUN. mode output is registered and equals state.
- RUN: run_en=1; inc_sec = tick_1hz delayed 1 cycle; inc and dec presses ignored.
- SET_HR/SET_MIN: run_en=0; tick_1hz ignored. An inc press gives inc_hr or inc_min; a dec press gives dec_hr or dec_min.
- SET_SEC: run_en=0; an inc or dec press gives clr_sec.
- SET_SEC->RUN: pre_clr is pulsed in the same cycle the state enters RUN.
- Auto-repeat (SET_HR/SET_MIN only): a hold counter starts at the press strobe. After REPEAT_DELAY cycles of continuous hold, one strobe fires, then one every REPEAT_RATE cycles until release. Release or a mode change clears the counter.
- Priority, same cycle:
  - Mode press beats inc/dec: the state changes and no adjust strobe is issued.
  - inc and dec both pressed or both held: no strobe; the hold counter is cleared.
  - Mode press in RUN coincident with a tick: the tick is dropped, since the clock stops.
- At most one of the inc_*, dec_*, clr_sec strobes is high in any cycle.
- Blink: in set modes a counter toggles blink_on every BLINK_HALF cycles. On entry to each set mode, blink_on=1 and the counter is 0. In RUN, blink_on=1.
- blink_sel for each set mode: SET_HR 100, SET_MIN 010, SET_SEC 001.
- Glitch rule: a key low for less than 2 sampled cycles may be missed. It never produces more than one strobe.

Test Plan:
(Bench overrides: REPEAT_DELAY=8, REPEAT_RATE=4, BLINK_HALF=3.)
1. Reset, then three tick_1hz pulses -> three inc_sec pulses, each 1 cycle after its tick. mode=0, run_en=1, blink_sel=000.
2. Mode press ×1, then inc pressed for 2 cycles ×2 -> mode=1, run_en=0, exactly two inc_hr strobes. Ticks during SET_HR produce no inc_sec.
3. Mode press ×2 from RUN, then dec held 20 cycles -> mode=2, dec_min strobes at hold cycles 0, 8, 12, 16 (4 total), no repeats after release.
4. Mode press ×3 from RUN, inc press -> clr_sec once. A 4th mode press gives mode=0, one pre_clr in the entry cycle, run_en=1.
5. In SET_MIN: inc and dec pressed together -> no strobes. Mode and inc pressed together -> mode=3, no inc_min.
6. In SET_HR, rst_n pulsed low mid-hold -> outputs take reset values immediately, no strobes after release. blink_on toggles every 3 cycles in set modes and is 1 in RUN.
